// File: rtl/md_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package md_unit_pkg;

    // RV32M funct3 encoding of the M-extension operations
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } md_state_e;

    localparam int unsigned MD_ITERATIONS = 32;
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

    // rs1 is interpreted as signed
    function automatic logic a_is_signed(input md_funct3_e f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    // rs2 is interpreted as signed
    function automatic logic b_is_signed(input md_funct3_e f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the shared multiply/divide datapath.
// Multiply: shift-add of opnd into the {hi, lo} accumulator (lo holds the multiplier).
// Divide:   restoring step; {hi, lo} shifts left, hi trial-subtracts opnd, quotient bit enters lo.
module md_iter_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] nxt_hi,
    output logic [XLEN-1:0] nxt_lo
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   cand;
    logic [XLEN-1:0] diff;
    logic            no_borrow;

    // Single-iteration next accumulator value for either operation
    always_comb begin
        sum       = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        cand      = {acc_hi, acc_lo[XLEN-1]};
        no_borrow = cand >= {1'b0, opnd};
        // Only used when no borrow, where the true difference fits in XLEN bits
        diff      = cand[XLEN-1:0] - opnd;
        if (is_div) begin
            nxt_hi = no_borrow ? diff : cand[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], no_borrow};
        end else begin
            nxt_hi = sum[XLEN:1];
            nxt_lo = {sum[0], acc_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide responder with valid/ready request and response.
// Optional build macro MD_FAST_MUL_EN: multiplies use a single-cycle 33x33 signed product.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    localparam int unsigned DW = 2 * XLEN;

    md_state_e       state_q, state_d;
    md_funct3_e      op_q, f_in;
    logic [4:0]      cnt_q;
    logic            sign_q;
    logic [XLEN-1:0] opnd_q, hi_q, lo_q, result_q;
    logic [XLEN-1:0] nxt_hi, nxt_lo;
    logic            accept, a_neg, b_neg, sign_in, div_zero, div_ovf, special, fast_mul;
    logic [XLEN-1:0] a_mag, b_mag, special_result, half, fix_result;
    logic [DW-1:0]   full, prod;

    assign accept      = req_valid & req_ready;
    assign resp_result = result_q;

`ifdef MD_FAST_MUL_EN
    logic          a_sx_q, b_sx_q;
    logic [DW-1:0] fast_prod;
    // Raw operands sit in opnd_q/lo_q; sign-extend each to 33 bits as the op requires
    assign fast_prod = $signed({{XLEN{a_sx_q & opnd_q[XLEN-1]}}, opnd_q})
                     * $signed({{XLEN{b_sx_q & lo_q[XLEN-1]}}, lo_q});
    assign fast_mul  = (state_q == CALC) & ~op_q[2];
`else
    assign fast_mul  = 1'b0;
`endif

    md_iter_step #(.XLEN(XLEN)) u_step (
        .is_div (op_q[2]),
        .acc_hi (hi_q),
        .acc_lo (lo_q),
        .opnd   (opnd_q),
        .nxt_hi (nxt_hi),
        .nxt_lo (nxt_lo)
    );

    // Decode the incoming request: operand magnitudes, result sign, special cases
    always_comb begin
        f_in     = md_funct3_e'(req_funct3);
        a_neg    = a_is_signed(f_in) & req_a[XLEN-1];
        b_neg    = b_is_signed(f_in) & req_b[XLEN-1];
        a_mag    = a_neg ? -req_a : req_a;
        b_mag    = b_neg ? -req_b : req_b;
        // MULHSU has b_neg = 0, so the xor reduces to sign(a) there
        sign_in  = (f_in == MD_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero = f_in[2] & (req_b == '0);
        div_ovf  = ((f_in == MD_DIV) || (f_in == MD_REM))
                 & (req_a == {1'b1, {(XLEN-1){1'b0}}}) & (req_b == {XLEN{1'b1}});
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_result = f_in[1] ? req_a : DIV0_QUOTIENT;
        end else begin
            special_result = f_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Sign fix-up and half/quotient/remainder selection
    always_comb begin
        full = {hi_q, lo_q};
`ifdef MD_FAST_MUL_EN
        if (fast_mul) begin
            full = fast_prod;
        end
`endif
        // Negate the whole product so the borrow into the high half is correct
        prod = sign_q ? -full : full;
        if (!op_q[2]) begin
            half = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[DW-1:XLEN];
        end else begin
            half = op_q[1] ? hi_q : lo_q;
            if (sign_q) begin
                half = -half;
            end
        end
        fix_result = half;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; kill overrides everything
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept) state_d = special ? DONE : CALC;
                CALC: begin
                    if (fast_mul) begin
                        // The half select is folded into the single fast cycle
                        state_d = DONE;
                    end else if (cnt_q == '0) begin
                        state_d = FIX;
                    end
                end
                FIX:  state_d = DONE;
                DONE: if (resp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs; resp_valid depends on state only
    always_comb begin
        req_ready  = (state_q == IDLE) & ~kill;
        resp_valid = (state_q == DONE);
        busy       = (state_q != IDLE);
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MD_MUL;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
`ifdef MD_FAST_MUL_EN
            a_sx_q   <= 1'b0;
            b_sx_q   <= 1'b0;
`endif
        end else if (accept) begin
            op_q   <= f_in;
            sign_q <= sign_in;
            cnt_q  <= 5'(MD_ITERATIONS - 1);
            hi_q   <= '0;
            opnd_q <= f_in[2] ? b_mag : a_mag;
            lo_q   <= f_in[2] ? a_mag : b_mag;
            if (special) begin
                result_q <= special_result;
            end
`ifdef MD_FAST_MUL_EN
            if (!f_in[2]) begin
                opnd_q <= req_a;
                lo_q   <= req_b;
                sign_q <= 1'b0;
                a_sx_q <= a_is_signed(f_in);
                b_sx_q <= b_is_signed(f_in);
            end
`endif
        end else if (state_q == CALC) begin
            hi_q <= nxt_hi;
            lo_q <= nxt_lo;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 5'd1;
            end
            if (fast_mul) begin
                result_q <= fix_result;
            end
        end else if (state_q == FIX) begin
            result_q <= fix_result;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected results, a monitor pops and checks.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kill = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        busy;

    md_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kill        (kill),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rr_mode = 2;   // 0 random, 1 hold low, 2 always high
    bit          seen = 1'b0;
    logic [31:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference results from the RV32M definition using 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned up;
        bit              ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'd0: return a * b;
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MD_FAST_MUL_EN
        if (!f[2]) return 2;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Response-side ready driver
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0: resp_ready = 1'($urandom_range(0, 1));
            1: resp_ready = 1'b0;
            default: resp_ready = 1'b1;
        endcase
    end

    // Monitor: latency on first resp_valid, stability while waiting, result on handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            seen = 1'b0;
        end else begin
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 result %h expected no response",
                             resp_result);
                end else if (!seen) begin
                    check({sb_q[0].name, "_latency"}, 32'(cyc - sb_q[0].acc_cyc + 1),
                          32'(sb_q[0].lat));
                    seen = 1'b1;
                    held = resp_result;
                end else begin
                    check("resp_stable", resp_result, held);
                end
            end
            if (kill) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                seen = 1'b0;
            end else if (resp_valid && resp_ready && sb_q.size() > 0) begin
                check(sb_q[0].name, resp_result, sb_q[0].res);
                void'(sb_q.pop_front());
                seen = 1'b0;
            end
        end
    end

    // Present a request, wait (bounded) for acceptance and push the expectation
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        exp_t e;
        bit   rdy;
        bit   got = 1'b0;
        req_funct3 = f;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            got = rdy;
        end
        req_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got no acceptance expected req_ready within 300 cycles", name);
        end else begin
            e.res     = exp;
            e.lat     = ref_latency(f, a, b);
            e.acc_cyc = cyc;
            e.name    = name;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (sb_q.size() == 0);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        bit          hs;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1"); wait_drain();
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2");         wait_drain();
        issue(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2");         wait_drain();
        issue(3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, "divu_by0");             wait_drain();
        issue(3'd7, 32'h1234, 32'd0, 32'h1234, "remu_by0");                 wait_drain();
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");   wait_drain();
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");          wait_drain();

        // Kill 10 cycles into a DIVU with a new request presented in the kill cycle
        issue(3'd5, 32'hDEADBEEF, 32'h13, 32'hDEADBEEF / 32'h13, "divu_killed");
        repeat (9) @(posedge clk);
        #1;
        kill       = 1'b1;
        req_valid  = 1'b1;
        req_funct3 = 3'd0;
        req_a      = 32'd3;
        req_b      = 32'd5;
        @(negedge clk);
        check("kill_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("post_kill_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.res     = 32'd15;
            e.lat     = ref_latency(3'd0, 32'd3, 32'd5);
            e.acc_cyc = cyc;
            e.name    = "mul_3x5";
            sb_q.push_back(e);
        end
        req_valid = 1'b0;
        wait_drain();

        // Backpressure in DONE
        rr_mode = 1;
        issue(3'd1, 32'h89ABCDEF, 32'h7654321F, ref_result(3'd1, 32'h89ABCDEF, 32'h7654321F),
              "mulh_hold");
        hs = 1'b0;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            hs = resp_valid;
        end
        check("hold_reached_done", {31'd0, hs}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rr_mode = 2;
        hs = 1'b0;
        for (int i = 0; i < 10 && !hs; i++) begin
            @(negedge clk);
            hs = resp_valid && resp_ready;
            if (hs) check("hs_req_ready", {31'd0, req_ready}, 32'd0);
        end
        check("hold_handshake", {31'd0, hs}, 32'd1);
        @(negedge clk);
        check("after_hs_req_ready", {31'd0, req_ready}, 32'd1);
        check("after_hs_resp_valid", {31'd0, resp_valid}, 32'd0);
        wait_drain();

        // Asynchronous reset mid-operation
        issue(3'd4, 32'h00012345, 32'h00000077, 32'h00012345 / 32'h77, "div_reset");
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_resp_result", resp_result, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized back-to-back traffic with random response backpressure
        rr_mode = 0;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(f, a, b, ref_result(f, a, b), $sformatf("rand%0d_f%0d", i, f));
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
